// File: rtl/univ_shift_reg.sv
// Parametrised universal shift register: manual hold/load/shift/rotate/clear ops
// plus an auto-shift burst engine with start/busy/done handshake.
module univ_shift_reg #(
  parameter int N  = 8,
  parameter int LW = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    mode,
  input  logic [N-1:0]  d,
  input  logic          si_r,
  input  logic          si_l,
  input  logic          start,
  input  logic          burst_dir,
  input  logic [LW-1:0] burst_len,
  output logic [N-1:0]  q,
  output logic          so_r,
  output logic          so_l,
  output logic          busy,
  output logic          done,
  output logic [LW-1:0] shift_cnt
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam logic [LW-1:0] CNT_ZERO = {LW{1'b0}};
  localparam logic [LW-1:0] CNT_ONE  = {{(LW-1){1'b0}}, 1'b1};

  state_t        state_q, state_d;
  logic [N-1:0]  q_q, q_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          dir_q, dir_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      q_q     <= {N{1'b0}};
      cnt_q   <= CNT_ZERO;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state, datapath and handshake logic.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        // A zero-length start is not a burst: mode runs as if start were low.
        if (start && (burst_len != CNT_ZERO)) begin
          state_d = BURST;
          cnt_d   = burst_len;
          dir_d   = burst_dir;
          busy_d  = 1'b1;
        end else begin
          case (mode)
            3'b000:  q_d = q_q;
            3'b001:  q_d = d;
            3'b010:  q_d = {si_r, q_q[N-1:1]};
            3'b011:  q_d = {q_q[N-2:0], si_l};
            3'b100:  q_d = {q_q[0], q_q[N-1:1]};
            3'b101:  q_d = {q_q[N-2:0], q_q[N-1]};
            3'b110:  q_d = {q_q[N-1], q_q[N-1:1]};
            3'b111:  q_d = {N{1'b0}};
            default: q_d = q_q;
          endcase
        end
      end
      BURST: begin
        if (dir_q) begin
          q_d = {q_q[N-2:0], si_l};
        end else begin
          q_d = {si_r, q_q[N-1:1]};
        end
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  assign q         = q_q;
  assign so_r      = q_q[0];
  assign so_l      = q_q[N-1];
  assign busy      = busy_q;
  assign done      = done_q;
  assign shift_cnt = cnt_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg: directed scenarios plus randomized
// stimulus against a queue-based behavioural model.
module tb_univ_shift_reg;
  localparam int N  = 8;
  localparam int LW = $clog2(N) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    mode;
  logic [N-1:0]  d;
  logic          si_r, si_l, start, burst_dir;
  logic [LW-1:0] burst_len;
  logic [N-1:0]  q;
  logic          so_r, so_l, busy, done;
  logic [LW-1:0] shift_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  // Model: q value, pending burst shifts as a queue of directions, done flag.
  logic [N-1:0] m_q;
  bit           m_pend[$];
  bit           m_done;
  bit           done_seen;

  univ_shift_reg #(.N(N), .LW(LW)) dut (
    .clk(clk), .reset(reset), .mode(mode), .d(d), .si_r(si_r), .si_l(si_l),
    .start(start), .burst_dir(burst_dir), .burst_len(burst_len),
    .q(q), .so_r(so_r), .so_l(so_l), .busy(busy), .done(done),
    .shift_cnt(shift_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] lsh(input logic [N-1:0] v, input bit in_bit);
    return (v << 1) | N'(in_bit);
  endfunction

  function automatic logic [N-1:0] rsh(input logic [N-1:0] v, input bit in_bit);
    return (v >> 1) | (N'(in_bit) << (N - 1));
  endfunction

  task automatic model_reset();
    m_q = '0;
    m_pend.delete();
    m_done = 0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    if (m_pend.size() > 0) begin
      bit left;
      left = m_pend.pop_front();
      m_q = left ? lsh(m_q, si_l) : rsh(m_q, si_r);
      m_done = (m_pend.size() == 0);
    end else begin
      m_done = 0;
      if (start && burst_len != 0) begin
        for (int i = 0; i < int'(burst_len); i++) m_pend.push_back(burst_dir);
      end else begin
        case (mode)
          3'd1: m_q = d;
          3'd2: m_q = rsh(m_q, si_r);
          3'd3: m_q = lsh(m_q, si_l);
          3'd4: m_q = rsh(m_q, m_q[0]);
          3'd5: m_q = lsh(m_q, m_q[N-1]);
          3'd6: m_q = N'($signed(m_q) >>> 1);
          3'd7: m_q = '0;
          default: ;
        endcase
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".q"},    32'(q),         32'(m_q));
    check({tag, ".busy"}, 32'(busy),      32'(m_pend.size() > 0));
    check({tag, ".done"}, 32'(done),      32'(m_done));
    check({tag, ".cnt"},  32'(shift_cnt), 32'(m_pend.size()));
    check({tag, ".so_r"}, 32'(so_r),      32'(m_q[0]));
    check({tag, ".so_l"}, 32'(so_l),      32'(m_q[N-1]));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    if (done) done_seen = 1;
    compare_all(tag);
  endtask

  task automatic manual(input logic [2:0] m, input logic [N-1:0] dv, input string tag);
    mode = m; d = dv; start = 1'b0;
    step(tag);
  endtask

  task automatic do_reset(input string tag);
    #3 reset = 1'b1;
    #1;
    model_reset();
    check({tag, ".q0"},    32'(q), 32'h0);
    check({tag, ".busy0"}, 32'(busy), 32'h0);
    check({tag, ".done0"}, 32'(done), 32'h0);
    check({tag, ".cnt0"},  32'(shift_cnt), 32'h0);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; mode = 3'd0; d = '0; si_r = 1'b0; si_l = 1'b0;
    start = 1'b0; burst_dir = 1'b0; burst_len = '0;
    model_reset();
    done_seen = 0;
    #12;
    compare_all("por");
    reset = 1'b0;

    // Reset with q=0xFF must clear before the next edge.
    manual(3'd1, 8'hFF, "ld_ff");
    do_reset("rst_ff");

    // Load/rotate/hold.
    manual(3'd1, 8'hA5, "ld_a5");
    manual(3'd4, 8'h00, "rotr");
    check("rotr_val", 32'(q), 32'hD2);
    manual(3'd1, 8'hA5, "ld_a5b");
    manual(3'd5, 8'h00, "rotl");
    check("rotl_val", 32'(q), 32'h4B);
    for (int i = 0; i < 3; i++) manual(3'd0, 8'h00, "hold");
    check("hold_val", 32'(q), 32'h4B);

    // Shifts from 0x96.
    si_r = 1'b0; si_l = 1'b1;
    manual(3'd1, 8'h96, "ld_96a"); manual(3'd2, 8'h00, "shr");
    check("shr_val", 32'(q), 32'h4B);
    manual(3'd1, 8'h96, "ld_96b"); manual(3'd6, 8'h00, "asr");
    check("asr_val", 32'(q), 32'hCB);
    manual(3'd1, 8'h96, "ld_96c"); manual(3'd3, 8'h00, "shl");
    check("shl_val", 32'(q), 32'h2D);
    manual(3'd1, 8'h96, "ld_96d"); manual(3'd7, 8'h00, "clr");
    check("clr_val", 32'(q), 32'h00);

    // Burst of 3 right shifts from 0x81, with load mode and a restart while busy.
    manual(3'd1, 8'h81, "ld_81");
    si_r = 1'b0; mode = 3'd0; start = 1'b1; burst_len = LW'(3); burst_dir = 1'b0;
    step("b_start");
    check("b_cnt3", 32'(shift_cnt), 32'd3);
    check("b_busy", 32'(busy), 32'd1);
    mode = 3'd1; d = 8'hFF; start = 1'b1; burst_len = LW'(7); burst_dir = 1'b1;
    step("b1"); check("b1_q", 32'(q), 32'h40); check("b1_cnt", 32'(shift_cnt), 32'd2);
    start = 1'b0;
    step("b2"); check("b2_q", 32'(q), 32'h20);
    step("b3"); check("b3_q", 32'(q), 32'h10);
    check("b3_done", 32'(done), 32'd1); check("b3_busy", 32'(busy), 32'd0);
    check("b3_cnt", 32'(shift_cnt), 32'd0);
    mode = 3'd0;
    step("b_after"); check("b_done_low", 32'(done), 32'd0);

    // Zero-length start behaves like hold.
    start = 1'b1; burst_len = '0; mode = 3'd0;
    step("len0"); check("len0_q", 32'(q), 32'h10);
    check("len0_busy", 32'(busy), 32'd0);
    step("len0b"); check("len0_done", 32'(done), 32'd0);

    // Back-to-back bursts: restart in the done cycle.
    start = 1'b1; burst_len = LW'(1); burst_dir = 1'b1; si_l = 1'b1;
    step("bb1");
    step("bb1_end"); check("bb_done", 32'(done), 32'd1);
    step("bb2_start"); check("bb2_busy", 32'(busy), 32'd1);
    start = 1'b0;
    step("bb2_end");

    // Reset mid-burst: no done afterwards.
    start = 1'b1; burst_len = LW'(5); burst_dir = 1'b0;
    step("rb_start"); start = 1'b0;
    step("rb1"); step("rb2");
    done_seen = 0;
    do_reset("rb_rst");
    for (int i = 0; i < 6; i++) step("rb_post");
    check("rb_no_done", 32'(done_seen), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      mode      = 3'($urandom_range(0, 7));
      d         = N'($urandom);
      si_r      = 1'($urandom);
      si_l      = 1'($urandom);
      start     = ($urandom_range(0, 7) == 0);
      burst_dir = 1'($urandom);
      burst_len = LW'($urandom_range(0, (1 << LW) - 1));
      if ($urandom_range(0, 99) == 0) do_reset("rnd_rst");
      else step("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
